// File: rtl/regmst_pkg.sv
// Shared types and helpers for the APB-to-reg_native register-tree master.
package regmst_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 64;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_APB_ADDR_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT_CYC    = 256;
  localparam int unsigned MAX_ADDR_WIDTH     = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } regmst_state_e;

  // Keeps the low w bits of a and forces every bit above them to zero.
  function automatic logic [MAX_ADDR_WIDTH-1:0] zext_addr(
    input logic [MAX_ADDR_WIDTH-1:0] a,
    input int unsigned               w
  );
    logic [MAX_ADDR_WIDTH-1:0] r;
    for (int unsigned i = 0; i < MAX_ADDR_WIDTH; i++) begin
      r[i] = (i < w) ? a[i] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/regmst_timeout_cnt.sv
// WAIT-state response timeout counter; only instantiated when REGMST_TIMEOUT_EN is defined.
module regmst_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic regdisp_disp_map_clk,
  input  logic regdisp_disp_map_rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge regdisp_disp_map_clk or negedge regdisp_disp_map_rst_n) begin
    if (!regdisp_disp_map_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive WAIT cycle.
  assign expired = inc && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/regmst_apb2native.sv
// APB3 slave to reg_native_if master at the root of the register tree; one outstanding request.
// Optional response timeout enabled by defining REGMST_TIMEOUT_EN.
module regmst_apb2native
  import regmst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input  logic                      regdisp_disp_map_clk,
  input  logic                      regdisp_disp_map_rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  input  logic                      soft_rst_req,
  output logic                      upstream__regdisp_disp_map__req_vld,
  output logic [ADDR_WIDTH-1:0]     upstream__regdisp_disp_map__addr,
  output logic                      upstream__regdisp_disp_map__wr_en,
  output logic                      upstream__regdisp_disp_map__rd_en,
  output logic [DATA_WIDTH-1:0]     upstream__regdisp_disp_map__wr_data,
  output logic                      upstream__regdisp_disp_map__soft_rst,
  input  logic                      regdisp_disp_map__upstream__ack_vld,
  input  logic                      regdisp_disp_map__upstream__err,
  input  logic [DATA_WIDTH-1:0]     regdisp_disp_map__upstream__rd_data
);

  if ((APB_ADDR_WIDTH > ADDR_WIDTH) || (ADDR_WIDTH > MAX_ADDR_WIDTH) || (TIMEOUT_CYC < 2))
  begin : g_bad_cfg
    $error("regmst_apb2native: invalid parameter combination");
  end

  regmst_state_e           state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic                    wr_en_q,   wr_en_d;
  logic                    rd_en_q,   rd_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    err_q,     err_d;
  logic                    soft_rst_q;
  logic                    finish;
  logic                    timeout_expired;

`ifdef REGMST_TIMEOUT_EN
  regmst_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .regdisp_disp_map_clk   (regdisp_disp_map_clk),
    .regdisp_disp_map_rst_n (regdisp_disp_map_rst_n),
    .clr                    (state_q != WAIT),
    .inc                    (state_q == WAIT),
    .expired                (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d   = REQ;
          addr_d    = ADDR_WIDTH'(zext_addr(MAX_ADDR_WIDTH'(paddr), APB_ADDR_WIDTH));
          wr_en_d   = pwrite;
          rd_en_d   = !pwrite;
          wr_data_d = pwrite ? pwdata : '0;
        end
      end
      REQ, WAIT: begin
        // The ack is checked first so it beats a timeout in the same cycle.
        if (regdisp_disp_map__upstream__ack_vld) begin
          rd_data_d = wr_en_q ? '0 : regdisp_disp_map__upstream__rd_data;
          err_d     = regdisp_disp_map__upstream__err;
          finish    = 1'b1;
        end else if (timeout_expired) begin
          rd_data_d = '0;
          err_d     = 1'b1;
          finish    = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      addr_d  = '0;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge regdisp_disp_map_clk or negedge regdisp_disp_map_rst_n) begin
    if (!regdisp_disp_map_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      soft_rst_q <= soft_rst_req;
    end
  end

  // Outputs come only from flops or the state decode; nothing from APB reaches them combinationally.
  assign pready  = (state_q == DONE);
  assign prdata  = pready ? rd_data_q : '0;
  assign pslverr = pready & err_q;

  assign upstream__regdisp_disp_map__req_vld  = (state_q == REQ);
  assign upstream__regdisp_disp_map__addr     = addr_q;
  assign upstream__regdisp_disp_map__wr_en    = wr_en_q;
  assign upstream__regdisp_disp_map__rd_en    = rd_en_q;
  assign upstream__regdisp_disp_map__wr_data  = wr_data_q;
  assign upstream__regdisp_disp_map__soft_rst = soft_rst_q;

endmodule

// File: tb/tb_regmst_apb2native.sv
// Randomized bench for regmst_apb2native: a cycle-indexed timeline model built from the latency rules.
module tb_regmst_apb2native;

  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int PAW  = 32;
  localparam int TO   = 16;
  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [PAW-1:0] paddr = '0;
  logic [DW-1:0]  pwdata = '0;
  logic           soft_rst_req = 1'b0;
  logic           ack_vld = 1'b0, ack_err = 1'b0;
  logic [DW-1:0]  ack_rd = '0;

  logic           pready, pslverr;
  logic [DW-1:0]  prdata;
  logic           n_req, n_wr, n_rd, n_soft;
  logic [AW-1:0]  n_addr;
  logic [DW-1:0]  n_wdata;

  regmst_apb2native #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(PAW), .TIMEOUT_CYC(TO)
  ) dut (
    .regdisp_disp_map_clk                 (clk),
    .regdisp_disp_map_rst_n               (rst_n),
    .psel                                 (psel),
    .penable                              (penable),
    .pwrite                               (pwrite),
    .paddr                                (paddr),
    .pwdata                               (pwdata),
    .pready                               (pready),
    .prdata                               (prdata),
    .pslverr                              (pslverr),
    .soft_rst_req                         (soft_rst_req),
    .upstream__regdisp_disp_map__req_vld  (n_req),
    .upstream__regdisp_disp_map__addr     (n_addr),
    .upstream__regdisp_disp_map__wr_en    (n_wr),
    .upstream__regdisp_disp_map__rd_en    (n_rd),
    .upstream__regdisp_disp_map__wr_data  (n_wdata),
    .upstream__regdisp_disp_map__soft_rst (n_soft),
    .regdisp_disp_map__upstream__ack_vld  (ack_vld),
    .regdisp_disp_map__upstream__err      (ack_err),
    .regdisp_disp_map__upstream__rd_data  (ack_rd)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expected outputs per cycle; cycle k is the interval after the k-th rising edge.
  bit            exp_req    [NCYC];
  bit            exp_pready [NCYC];
  bit            exp_act    [NCYC];
  bit            exp_clr    [NCYC];
  bit            exp_wr     [NCYC];
  logic [AW-1:0] exp_addr   [NCYC];
  logic [DW-1:0] exp_wdata  [NCYC];
  logic [DW-1:0] exp_prdata [NCYC];
  bit            exp_perr   [NCYC];

  int            obs_pready_cyc = 0, obs_pready_cnt = 0, obs_req_cnt = 0;
  logic [DW-1:0] obs_prdata = '0;
  logic          obs_perr = 1'b0, obs_req_wr = 1'b0;
  logic [AW-1:0] obs_req_addr = '0;
  int            last_setup = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: sample 1 time unit after each rising edge.
  initial begin
    bit soft_exp;
    forever begin
      @(posedge clk);
      soft_exp = rst_n ? soft_rst_req : 1'b0;
      cyc++;
      #1;
      if (cyc >= NCYC) begin
        $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, NCYC);
        $fatal(1, "cycle budget exhausted");
      end
      if (!rst_n) soft_exp = 1'b0;
      check("pready", pready, exp_pready[cyc]);
      check("req_vld", n_req, exp_req[cyc]);
      check("soft_rst", n_soft, soft_exp);
      if (exp_pready[cyc]) begin
        check("prdata", prdata, exp_prdata[cyc]);
        check("pslverr", pslverr, exp_perr[cyc]);
      end
      if (exp_act[cyc]) begin
        check("addr", n_addr, exp_addr[cyc]);
        check("wr_en", n_wr, exp_wr[cyc]);
        check("rd_en", n_rd, !exp_wr[cyc]);
        check("wr_data", n_wdata, exp_wdata[cyc]);
      end
      if (exp_clr[cyc] || !rst_n) begin
        check("addr_clr", n_addr, '0);
        check("wr_en_clr", n_wr, 1'b0);
        check("rd_en_clr", n_rd, 1'b0);
      end
      if (!rst_n) begin
        check("rst_prdata", prdata, '0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_wr_data", n_wdata, '0);
      end
      if (pready) begin
        obs_pready_cyc = cyc;
        obs_pready_cnt++;
        obs_prdata = prdata;
        obs_perr = pslverr;
      end
      if (n_req) begin
        obs_req_cnt++;
        obs_req_addr = n_addr;
        obs_req_wr = n_wr;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) soft_rst_req = ~soft_rst_req;
    end
  end

  task automatic idle(input int n, input bit stray);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      pwrite = 1'($urandom); paddr = $urandom;
      ack_vld = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      ack_err = 1'($urandom); ack_rd = $urandom;
    end
  endtask

  // n_ack: cycles after REQ at which the dispatcher acks (negative = never).
  // rst_after: cycles after REQ at which reset is pulsed (negative = never).
  task automatic xfer(input bit wr, input logic [PAW-1:0] a, input logic [DW-1:0] wd,
                      input int n_ack, input bit aerr, input logic [DW-1:0] ard,
                      input int rst_after, input bit stray);
    int c, d;
    bit to;
    @(negedge clk);
    c = cyc;
    last_setup = c;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    ack_vld = 1'b0;
`ifdef REGMST_TIMEOUT_EN
    to = (n_ack < 0) || (n_ack > TO);
`else
    to = 1'b0;
`endif
    d = to ? c + 2 + TO : c + 2 + n_ack;
    exp_req[c+1] = 1'b1;
    for (int k = c + 1; k < d; k++) begin
      exp_act[k]   = 1'b1;
      exp_addr[k]  = {{(AW-PAW){1'b0}}, a};
      exp_wr[k]    = wr;
      exp_wdata[k] = wr ? wd : '0;
    end
    exp_pready[d] = 1'b1;
    exp_clr[d]    = 1'b1;
    exp_prdata[d] = (wr || to) ? '0 : ard;
    exp_perr[d]   = to ? 1'b1 : aerr;
    for (int k = c + 1; k <= d; k++) begin
      @(negedge clk);
      penable = (stray && k > c + 1 && k < d && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if (rst_after >= 0 && k == c + 1 + rst_after) begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; ack_vld = 1'b0;
        for (int j = k + 1; j <= d; j++) begin
          exp_req[j] = 1'b0; exp_act[j] = 1'b0; exp_pready[j] = 1'b0; exp_clr[j] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (n_ack >= 0 && k == c + 1 + n_ack) begin
        ack_vld = 1'b1; ack_err = aerr; ack_rd = ard;
      end else begin
        ack_vld = (k == d) ? 1'($urandom_range(0, 1)) : 1'b0;
        ack_err = 1'($urandom); ack_rd = $urandom;
      end
    end
  endtask

  initial begin
    int pcnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Write acked in the REQ cycle: pready two cycles after the setup cycle.
    xfer(1'b1, 32'h0000_1004, 32'hA5A5_0001, 0, 1'b0, '0, -1, 1'b0);
    check("t1_latency", 64'(obs_pready_cyc - last_setup), 64'd2);
    check("t1_req_addr", obs_req_addr, 64'h0000_0000_0000_1004);
    check("t1_req_wr", obs_req_wr, 1'b1);
    check("t1_pslverr", obs_perr, 1'b0);
    idle(2, 1'b0);

    obs_req_cnt = 0;
    xfer(1'b0, 32'h0000_0010, '0, 3, 1'b0, 32'hDEAD_BEEF, -1, 1'b0);
    check("t2_latency", 64'(obs_pready_cyc - last_setup), 64'd5);
    check("t2_prdata", obs_prdata, 32'hDEAD_BEEF);
    check("t2_req_pulses", 64'(obs_req_cnt), 64'd1);
    idle(1, 1'b1);

    xfer(1'b0, 32'h0000_0014, '0, 1, 1'b1, 32'h0BAD_0BAD, -1, 1'b0);
    check("t3_pslverr", obs_perr, 1'b1);
    xfer(1'b0, 32'h0000_0018, '0, 2, 1'b0, 32'h1234_5678, -1, 1'b0);
    check("t3_next_pslverr", obs_perr, 1'b0);
    check("t3_next_prdata", obs_prdata, 32'h1234_5678);
    idle(1, 1'b0);

`ifdef REGMST_TIMEOUT_EN
    xfer(1'b0, 32'h0000_0040, '0, -1, 1'b0, '0, -1, 1'b0);
    check("t4_latency", 64'(obs_pready_cyc - last_setup), 64'd18);
    check("t4_pslverr", obs_perr, 1'b1);
    check("t4_prdata", obs_prdata, '0);
    pcnt = obs_pready_cnt;
    idle(1, 1'b0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; ack_vld = 1'b1; ack_err = 1'b1; ack_rd = 32'hFEED_FACE;
    idle(3, 1'b0);
    check("t4_late_ack", 64'(obs_pready_cnt), 64'(pcnt));
    xfer(1'b0, 32'h0000_0044, '0, TO, 1'b0, 32'h600D_600D, -1, 1'b0);
    check("t4_ack_wins_prdata", obs_prdata, 32'h600D_600D);
    check("t4_ack_wins_pslverr", obs_perr, 1'b0);
`else
    xfer(1'b0, 32'h0000_0040, '0, 40, 1'b0, 32'h0404_0404, -1, 1'b0);
    check("t4_long_latency", 64'(obs_pready_cyc - last_setup), 64'd42);
    check("t4_long_prdata", obs_prdata, 32'h0404_0404);
`endif
    idle(1, 1'b0);

    pcnt = obs_pready_cnt;
    xfer(1'b0, 32'h0000_0020, '0, 10, 1'b0, 32'h0000_0BAD, 2, 1'b0);
    idle(12, 1'b0);
    check("t5_no_pready", 64'(obs_pready_cnt), 64'(pcnt));
    xfer(1'b1, 32'h0000_0024, 32'h0000_0005, 1, 1'b0, '0, -1, 1'b0);
    check("t5_after_rst_latency", 64'(obs_pready_cyc - last_setup), 64'd3);

    xfer(1'b0, 32'h0000_0100, '0, 0, 1'b0, 32'h1111_1111, -1, 1'b0);
    check("t6_rd0", obs_prdata, 32'h1111_1111);
    xfer(1'b1, 32'h0000_0104, 32'h2222_2222, 1, 1'b0, 32'hFFFF_FFFF, -1, 1'b0);
    check("t6_wr_prdata", obs_prdata, '0);
    xfer(1'b0, 32'h0000_0108, '0, 5, 1'b0, 32'h3333_3333, -1, 1'b0);
    check("t6_rd5", obs_prdata, 32'h3333_3333);
    check("t6_latency", 64'(obs_pready_cyc - last_setup), 64'd7);

    for (int i = 0; i < 150; i++) begin
      int n;
      int r;
      n = $urandom_range(0, 6);
      r = $urandom_range(0, 19);
`ifdef REGMST_TIMEOUT_EN
      if (r == 0) n = -1;
      else if (r == 1) n = TO;
      else if (r == 2) n = TO + 1;
`endif
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, n, ($urandom_range(0, 3) == 0),
           $urandom, -1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2), 1'b1);
    end
    idle(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
